magic_canvas: RTL
=================

// Module: magic_canvas
// PURPOSE
//  Producer side of the 900-bit handwrite interface. Accepts pen points in display coordinates
//  and paints them into a 30x30 bitmap (bit index = gy*30+gx) with a square brush.
//  On submit it pulses the classifier's active-low start, holds the bitmap frozen, then
//  latches the returned digit. Timeout if no result. Sits between pen/touch front end and classifier.
// PARAMETERS
//  ORIGIN_X    200   display x of canvas cell (0,0) left edge
//  ORIGIN_Y    120   display y of canvas cell (0,0) top edge
//  CELL_SHIFT  3     log2 pixels per cell side (8 px -> 240x240 px canvas)
//  BRUSH_R     1     brush radius in cells (0 -> 1x1, 1 -> 3x3)
//  TIMEOUT     2047  max cycles in S_WAIT before giving up (classifier needs ~906)
// PORTS
//  i_clk          in   1    clock
//  i_rst_n        in   1    async active-low reset
//  i_pen_valid    in   1    pen point offered
//  i_pen_x        in   10   pen display x
//  i_pen_y        in   10   pen display y
//  o_pen_ready    out  1    point accepted when i_pen_valid & o_pen_ready
//  i_clear        in   1    request bitmap wipe (level, sampled in S_IDLE)
//  i_submit       in   1    request classification (level, sampled in S_IDLE)
//  o_handwrite    out  900  bitmap to classifier, registered
//  o_start_n      out  1    active-low start pulse to classifier
//  i_digit        in   4    classifier result
//  i_digit_valid  in   1    classifier result strobe
//  o_digit        out  4    latched result
//  o_digit_valid  out  1    sticky: result held in o_digit
//  o_timeout      out  1    sticky: last submit timed out
//  o_busy         out  1    state != S_IDLE
// BEHAVIOUR
//  Reset: state S_IDLE, o_handwrite=0, o_start_n=1, o_digit=0, o_digit_valid=0, o_timeout=0.
//  o_pen_ready = (state==S_IDLE) & !i_clear & !i_submit (combinational on i_clear/i_submit).
//  S_IDLE priority: i_clear > i_submit > pen handshake.
//   i_clear  -> S_CLEAR, row ctr=0, o_digit_valid=0, o_timeout=0.
//   i_submit -> S_START, o_digit_valid=0, o_timeout=0.
//   pen accept: in-region if ORIGIN_X<=px<ORIGIN_X+(30<<CELL_SHIFT), same for y;
//    gx=(px-ORIGIN_X)>>CELL_SHIFT, gy likewise; latch gx,gy; -> S_PAINT, row ctr=0.
//    out-of-region: accepted, bitmap untouched, stay S_IDLE.
//  S_PAINT: one brush row per cycle, row r = gy-BRUSH_R+ctr, ctr 0..2*BRUSH_R;
//   OR 1s into cols gx-BRUSH_R..gx+BRUSH_R; rows/cols outside 0..29 clipped (no wrap);
//   last row -> S_IDLE. Occupies 2*BRUSH_R+1 cycles; painting only sets bits.
//  S_CLEAR: zero row ctr (30 bits) per cycle, ctr 0..29; after row 29 -> S_IDLE (30 cycles).
//  S_START: o_start_n=0 for exactly this one cycle; timeout ctr=0; -> S_WAIT.
//  S_WAIT: o_handwrite frozen; i_clear/i_submit/pen ignored (ready=0).
//   i_digit_valid -> o_digit<=i_digit, o_digit_valid<=1, -> S_IDLE.
//   else ctr==TIMEOUT-1 -> o_timeout<=1, -> S_IDLE; else ctr++ (11-bit, no wrap).
//  i_digit_valid outside S_WAIT ignored. o_start_n registered, high in all other states.
//  Reset asserted mid-operation: immediate return to reset values; no partial row committed.
// TESTING
//  1 Reset, BRUSH_R=1: all outputs at reset values, o_pen_ready=1 with idle inputs.
//  2 Pen (200,120) -> bits 0,1,30,31 set only; o_pen_ready low 3 cycles, o_busy high 3 cycles.
//  3 Pen (439,359) -> cell (29,29); bits 868,869,898,899 set only (clipping at far edge).
//  4 Pen (100,50) and (440,120) -> accepted, bitmap unchanged, no S_PAINT entry.
//  5 Submit -> o_start_n low exactly 1 cycle; pen offered in S_WAIT not accepted; i_digit=7
//    valid 906 cycles later -> o_digit=7, o_digit_valid=1, back to S_IDLE.
//  6 Submit with no i_digit_valid -> o_timeout=1 after 2047 S_WAIT cycles; then i_clear ->
//    30 busy cycles, o_handwrite=0, o_timeout=0, o_digit_valid=0.

Source files
------------

// File: rtl/magic_canvas.sv
// magic_canvas: paints pen points into a 30x30 bitmap and runs the start/result handshake with the classifier
module magic_canvas #(
  parameter int ORIGIN_X   = 200,
  parameter int ORIGIN_Y   = 120,
  parameter int CELL_SHIFT = 3,
  parameter int BRUSH_R    = 1,
  parameter int TIMEOUT    = 2047
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_pen_valid,
  input  logic [9:0]   i_pen_x,
  input  logic [9:0]   i_pen_y,
  output logic         o_pen_ready,
  input  logic         i_clear,
  input  logic         i_submit,
  output logic [899:0] o_handwrite,
  output logic         o_start_n,
  input  logic [3:0]   i_digit,
  input  logic         i_digit_valid,
  output logic [3:0]   o_digit,
  output logic         o_digit_valid,
  output logic         o_timeout,
  output logic         o_busy
);
  typedef enum logic [2:0] {S_IDLE, S_PAINT, S_CLEAR, S_START, S_WAIT} state_t;
  state_t state, state_n;
  logic [4:0] ctr, gx, gy, pgx, pgy;
  logic [10:0] tctr;
  logic [29:0] mask;
  logic [9:0] pbase, cbase;
  logic in_reg, row_ok, pen_acc;
  int px, py, row;
  assign o_pen_ready = state == S_IDLE && !i_clear && !i_submit;
  assign o_busy = state != S_IDLE;
  assign pen_acc = i_pen_valid && o_pen_ready;
  always_comb begin
    px = int'(i_pen_x) - ORIGIN_X;
    py = int'(i_pen_y) - ORIGIN_Y;
    in_reg = px >= 0 && px < (30 << CELL_SHIFT) && py >= 0 && py < (30 << CELL_SHIFT);
    pgx = 5'(px >> CELL_SHIFT);
    pgy = 5'(py >> CELL_SHIFT);
    row = int'(gy) - BRUSH_R + int'(ctr);
    row_ok = row >= 0 && row < 30;
    pbase = 10'(row * 30);
    cbase = 10'(int'(ctr) * 30);
    mask = '0;
    // columns outside the grid simply never match, which gives the edge clipping
    for (int c = 0; c < 30; c++) mask[c] = c >= int'(gx) - BRUSH_R && c <= int'(gx) + BRUSH_R;
  end
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  state_n = i_clear ? S_CLEAR : i_submit ? S_START : (pen_acc && in_reg) ? S_PAINT : S_IDLE;
      S_PAINT: state_n = ctr == 5'(2 * BRUSH_R) ? S_IDLE : S_PAINT;
      S_CLEAR: state_n = ctr == 5'd29 ? S_IDLE : S_CLEAR;
      S_START: state_n = S_WAIT;
      S_WAIT:  state_n = (i_digit_valid || tctr == 11'(TIMEOUT - 1)) ? S_IDLE : S_WAIT;
      default: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n) state <= !i_rst_n ? S_IDLE : state_n;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_handwrite <= '0;
      o_start_n <= 1'b1;
      o_digit <= '0;
      o_digit_valid <= 1'b0;
      o_timeout <= 1'b0;
      ctr <= '0;
      tctr <= '0;
      gx <= '0;
      gy <= '0;
    end else begin
      o_start_n <= state_n != S_START;
      case (state)
        S_IDLE: begin
          if (i_clear || i_submit) begin
            o_digit_valid <= 1'b0;
            o_timeout <= 1'b0;
            ctr <= '0;
          end else if (pen_acc && in_reg) begin
            gx <= pgx;
            gy <= pgy;
            ctr <= '0;
          end
        end
        S_PAINT: begin
          if (row_ok) o_handwrite[pbase +: 30] <= o_handwrite[pbase +: 30] | mask;
          ctr <= ctr + 5'd1;
        end
        S_CLEAR: begin
          o_handwrite[cbase +: 30] <= '0;
          ctr <= ctr + 5'd1;
        end
        S_START: tctr <= '0;
        S_WAIT: begin
          if (i_digit_valid) begin
            o_digit <= i_digit;
            o_digit_valid <= 1'b1;
          end else if (tctr == 11'(TIMEOUT - 1)) o_timeout <= 1'b1;
          else tctr <= tctr + 11'd1;
        end
        default: ;
      endcase
    end
  end
endmodule
